exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Multi-cycle execution sequencer for the Reaper processor. It sits between the instruction control decoder and the PC/register-file/memory write enables.
- It stalls the PC and suppresses state commits while DIV/MOD run on the fixed-latency divider, while IN waits for user input, while OUT waits for the display to accept, and while the core is halted.
- It also keeps retired-instruction and stall-cycle counters for debug.

Parameters:
- DIV_CYCLES, 8: extra cycles a DIV/MOD (ALU_Op 3 or 4) occupies. 0 means single-cycle.
- CNT_WIDTH, 32: width of Instr_Count and Stall_Count.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  reset; asynchronous assert, active-low.
- Halt  input  1  decoded HALT of the current instruction.
- IO_Enable  input  1  decoded IN/OUT.
- IO_Selection  input  1  0 = IN, 1 = OUT.
- ALU_Op  input  5  decoded ALU operation.
- In_Valid  input  1  external input data present.
- Out_Ready  input  1  output device accepts data.
- Resume  input  1  synchronous level (debounced button). A rising edge leaves HALTED.
- PC_Enable  output  1  advance the PC this cycle. Combinational.
- Commit  output  1  gate for Reg_Write/Mem_Write/Stack_Write this cycle. Combinational.
- In_Ack  output  1  input consumed. Combinational.
- Out_Valid  output  1  output data valid. Registered.
- Halted  output  1  core halted. Registered.
- Busy  output  1  state != RUN. Registered.
- State  output  3  debug: RUN=0, DIV_WAIT=1, IN_WAIT=2, OUT_WAIT=3, HALTED=4.
- Instr_Count  output  CNT_WIDTH  retired instructions.
- Stall_Count  output  CNT_WIDTH  stall cycles.

Behaviour:
- Reset (Reset_n=0, asynchronous): State=RUN, Out_Valid=0, Halted=0, Busy=0, divide counter=0, both counts=0, Resume edge register=1 so a Resume held through reset gives no spurious edge.
- Reset mid-operation aborts any wait with no commit. The instruction restarts from RUN.
- RUN decode priority: Halt > IO_Enable > (ALU_Op==3 or 4, with DIV_CYCLES>0) > normal.
  - Normal: PC_Enable=1, Commit=1. Stay in RUN.
  - Halt: PC_Enable=0, Commit=0. Next state HALTED; Halted=1 from the next cycle.
  - IN (IO_Enable=1, IO_Selection=0): PC_Enable=0, Commit=0. Next state IN_WAIT. In_Valid is ignored in this cycle.
  - OUT (IO_Enable=1, IO_Selection=1): PC_Enable=0, Commit=0. Next state OUT_WAIT; Out_Valid=1 from the next cycle.
  - DIV/MOD: PC_Enable=0, Commit=0. Load counter with DIV_CYCLES-1. Next state DIV_WAIT.
- DIV_WAIT:
  - counter != 0: decrement; PC_Enable=0, Commit=0.
  - counter == 0: PC_Enable=1, Commit=1. Next state RUN.
  - A DIV therefore spans exactly DIV_CYCLES+1 cycles.
- IN_WAIT:
  - In_Valid=0: hold; PC_Enable=0, Commit=0.
  - In_Valid=1: In_Ack=1, PC_Enable=1, Commit=1, next state RUN. In_Ack is high exactly one cycle per IN.
  - Minimum IN latency is 2 cycles.
- OUT_WAIT:
  - Out_Valid=1 throughout.
  - Out_Ready=1: PC_Enable=1, Commit=1, next state RUN. Out_Valid=0 from the next cycle.
  - Out_Ready high on the entry cycle completes the OUT in that cycle.
- HALTED:
  - Halted=1; PC_Enable=0, Commit=0.
  - A Resume rising edge (Resume=1 and previous sample 0): PC_Enable=1 (steps past HALT), Commit=0, next state RUN, Halted=0 from the next cycle.
  - A Resume held high gives only one step.
- In all states, Commit=0 whenever PC_Enable=0. Decoder inputs are only sampled in RUN; changes in wait states are ignored.
- Instr_Count increments on every cycle with PC_Enable=1 and wraps modulo 2^CNT_WIDTH.
- Stall_Count increments on every cycle with PC_Enable=0 and State != HALTED, counting the RUN entry cycle of a stalling instruction. It wraps modulo 2^CNT_WIDTH.
- Busy = (State != RUN), registered from the state register.

Test Plan:
- Reset, then 5 normal instructions (Halt=0, IO_Enable=0, ALU_Op=0) -> PC_Enable=Commit=1 for 5 cycles, Instr_Count=5, Stall_Count=0.
- ALU_Op=3 with DIV_CYCLES=8 -> PC_Enable=0 for 8 cycles, PC_Enable=Commit=1 on cycle 9, Instr_Count +1, Stall_Count +8. Repeat with DIV_CYCLES=0 -> single-cycle.
- IN with In_Valid raised 4 cycles after entry -> In_Ack one-cycle pulse coincident with PC_Enable=1, State back to 0; In_Valid held high from before the IN -> completes in exactly 2 cycles.
- OUT with Out_Ready=0 for 3 cycles then 1 -> Out_Valid=1 for 4 cycles, completion on the Out_Ready cycle, Out_Valid=0 next.
- HALT with Resume held high since reset -> stays HALTED; Resume 0 then 1 -> single PC_Enable pulse, Commit=0, Halted=0 next, Stall_Count unchanged while halted.
- Reset_n asserted mid-DIV_WAIT and mid-OUT_WAIT -> immediate State=0, Out_Valid=0, no Commit pulse, counts=0.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Multi-cycle execution sequencer for the Reaper core. It sits between the
//   control decoder and the PC / register-file / memory write enables. It
//   stalls the PC and suppresses commits while DIV/MOD occupy the
//   fixed-latency divider, while IN waits for input data, while OUT waits for
//   the display, and while the core is halted. It also keeps retired-
//   instruction and stall-cycle counters for debug.
//
// Ports
//   Clock_i        rising-edge system clock
//   Reset_n_i      asynchronous active-low reset
//   Halt_i         decoded HALT of the current instruction
//   IO_Enable_i    decoded IN/OUT
//   IO_Selection_i 0 = IN, 1 = OUT
//   ALU_Op_i       decoded ALU operation (3 = DIV, 4 = MOD)
//   In_Valid_i     external input data present
//   Out_Ready_i    output device accepts data
//   Resume_i       debounced level; a rising edge leaves HALTED
//   PC_Enable_o    advance PC this cycle (combinational)
//   Commit_o       gate for Reg/Mem/Stack writes this cycle (combinational)
//   In_Ack_o       input consumed (combinational)
//   Out_Valid_o    output data valid (registered)
//   Halted_o       core halted (registered)
//   Busy_o         state != RUN (registered)
//   State_o        debug state: RUN=0 DIV_WAIT=1 IN_WAIT=2 OUT_WAIT=3 HALTED=4
//   Instr_Count_o  retired instructions (wraps)
//   Stall_Count_o  stall cycles outside HALTED (wraps)
module exec_sequencer #(
   parameter int DIV_CYCLES = 8,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 Clock_i,
   input  logic                 Reset_n_i,
   input  logic                 Halt_i,
   input  logic                 IO_Enable_i,
   input  logic                 IO_Selection_i,
   input  logic [4:0]           ALU_Op_i,
   input  logic                 In_Valid_i,
   input  logic                 Out_Ready_i,
   input  logic                 Resume_i,
   output logic                 PC_Enable_o,
   output logic                 Commit_o,
   output logic                 In_Ack_o,
   output logic                 Out_Valid_o,
   output logic                 Halted_o,
   output logic                 Busy_o,
   output logic [2:0]           State_o,
   output logic [CNT_WIDTH-1:0] Instr_Count_o,
   output logic [CNT_WIDTH-1:0] Stall_Count_o
);

   typedef enum logic [2:0] {
      S_RUN      = 3'd0,
      S_DIV_WAIT = 3'd1,
      S_IN_WAIT  = 3'd2,
      S_OUT_WAIT = 3'd3,
      S_HALTED   = 3'd4
   } state_e;

   localparam int             DCW      = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam bit             DIV_EN   = (DIV_CYCLES > 0);
   localparam logic [DCW-1:0] DIV_LOAD = (DIV_CYCLES > 0) ? DCW'(DIV_CYCLES - 1) : '0;

   state_e                 state_q, state_d;
   logic [DCW-1:0]         div_cnt_q, div_cnt_d;
   logic                   out_valid_q, halted_q, busy_q;
   logic                   resume_q;
   logic [CNT_WIDTH-1:0]   instr_cnt_q, stall_cnt_q;
   logic                   pc_en_d, commit_d, in_ack_d;

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      pc_en_d   = 1'b0;
      commit_d  = 1'b0;
      in_ack_d  = 1'b0;
      case (state_q)
         S_RUN: begin
            if (Halt_i) begin
               state_d = S_HALTED;
            end else if (IO_Enable_i) begin
               state_d = IO_Selection_i ? S_OUT_WAIT : S_IN_WAIT;
            end else if (DIV_EN && (ALU_Op_i == 5'd3 || ALU_Op_i == 5'd4)) begin
               // RUN cycle counts as the first divider cycle, hence DIV_CYCLES-1
               state_d   = S_DIV_WAIT;
               div_cnt_d = DIV_LOAD;
            end else begin
               pc_en_d  = 1'b1;
               commit_d = 1'b1;
            end
         end
         S_DIV_WAIT: begin
            if (div_cnt_q != '0) begin
               div_cnt_d = div_cnt_q - DCW'(1);
            end else begin
               pc_en_d  = 1'b1;
               commit_d = 1'b1;
               state_d  = S_RUN;
            end
         end
         S_IN_WAIT: begin
            if (In_Valid_i) begin
               in_ack_d = 1'b1;
               pc_en_d  = 1'b1;
               commit_d = 1'b1;
               state_d  = S_RUN;
            end
         end
         S_OUT_WAIT: begin
            if (Out_Ready_i) begin
               pc_en_d  = 1'b1;
               commit_d = 1'b1;
               state_d  = S_RUN;
            end
         end
         S_HALTED: begin
            // Step past the HALT without committing anything
            if (Resume_i && !resume_q) begin
               pc_en_d = 1'b1;
               state_d = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // While reset is asserted nothing may advance or commit, so an aborted
   // wait never produces a spurious write.
   assign PC_Enable_o   = pc_en_d & Reset_n_i;
   assign Commit_o      = commit_d & pc_en_d & Reset_n_i;
   assign In_Ack_o      = in_ack_d & Reset_n_i;
   assign Out_Valid_o   = out_valid_q;
   assign Halted_o      = halted_q;
   assign Busy_o        = busy_q;
   assign State_o       = state_q;
   assign Instr_Count_o = instr_cnt_q;
   assign Stall_Count_o = stall_cnt_q;

   always_ff @(posedge Clock_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         state_q     <= S_RUN;
         div_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
         busy_q      <= 1'b0;
         resume_q    <= 1'b1;   // Resume held through reset is not an edge
         instr_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         // Flag outputs registered from the next state so they track State_o
         out_valid_q <= (state_d == S_OUT_WAIT);
         halted_q    <= (state_d == S_HALTED);
         busy_q      <= (state_d != S_RUN);
         resume_q    <= Resume_i;
         if (pc_en_d) begin
            instr_cnt_q <= instr_cnt_q + CNT_WIDTH'(1);
         end else if (state_q != S_HALTED) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer. Instance A uses DIV_CYCLES=8, instance B
// DIV_CYCLES=0; both share stimulus. Expected values are queued as each step
// is driven and popped when the outputs are sampled mid-cycle.
module tb_exec_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, halt, ioen, iosel, inv, ordy, resume;
   logic [4:0]  op;

   logic        a_pc, a_cm, a_ack, a_ov, a_hl, a_bz;
   logic [2:0]  a_st;
   logic [31:0] a_ic, a_sc;
   logic        b_pc, b_cm, b_ack, b_ov, b_hl, b_bz;
   logic [2:0]  b_st;
   logic [31:0] b_ic, b_sc;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      int          kind;
      logic [63:0] exp;
   } sb_t;
   sb_t sb_q[$];

   always #5 clk = ~clk;

   exec_sequencer #(.DIV_CYCLES(8), .CNT_WIDTH(32)) dut_a (
      .Clock_i(clk), .Reset_n_i(rst_n), .Halt_i(halt), .IO_Enable_i(ioen),
      .IO_Selection_i(iosel), .ALU_Op_i(op), .In_Valid_i(inv), .Out_Ready_i(ordy),
      .Resume_i(resume), .PC_Enable_o(a_pc), .Commit_o(a_cm), .In_Ack_o(a_ack),
      .Out_Valid_o(a_ov), .Halted_o(a_hl), .Busy_o(a_bz), .State_o(a_st),
      .Instr_Count_o(a_ic), .Stall_Count_o(a_sc));

   exec_sequencer #(.DIV_CYCLES(0), .CNT_WIDTH(32)) dut_b (
      .Clock_i(clk), .Reset_n_i(rst_n), .Halt_i(halt), .IO_Enable_i(ioen),
      .IO_Selection_i(iosel), .ALU_Op_i(op), .In_Valid_i(inv), .Out_Ready_i(ordy),
      .Resume_i(resume), .PC_Enable_o(b_pc), .Commit_o(b_cm), .In_Ack_o(b_ack),
      .Out_Valid_o(b_ov), .Halted_o(b_hl), .Busy_o(b_bz), .State_o(b_st),
      .Instr_Count_o(b_ic), .Stall_Count_o(b_sc));

   function automatic logic [63:0] observe(int kind);
      case (kind)
         0: return {55'd0, a_pc, a_cm, a_ack, a_st, a_ov, a_hl, a_bz};
         1: return {a_ic, a_sc};
         2: return {55'd0, b_pc, b_cm, b_ack, b_st, b_ov, b_hl, b_bz};
         default: return {b_ic, b_sc};
      endcase
   endfunction

   task automatic push_ctrl(input int kind, input string tag, input bit pc, input bit cm,
                            input bit ack, input logic [2:0] st, input bit ov,
                            input bit hl, input bit bz);
      sb_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = {55'd0, pc, cm, ack, st, ov, hl, bz};
      sb_q.push_back(e);
   endtask

   task automatic push_cnt(input int kind, input string tag, input int ic, input int sc);
      sb_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = {ic[31:0], sc[31:0]};
      sb_q.push_back(e);
   endtask

   // Let combinational outputs settle, then pop and compare everything queued
   task automatic settle_and_check();
      sb_t e;
      logic [63:0] obs;
      #1;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         obs = observe(e.kind);
         vectors++;
         assert (obs === e.exp)
            $display("ok   %-12s kind=%0d value=%h", e.tag, e.kind, obs);
         else begin
            miscompares++;
            $error("FAIL %s kind=%0d observed=%h expected=%h", e.tag, e.kind, obs, e.exp);
         end
      end
   endtask

   // One clock cycle of instance A with expected control outputs
   task automatic step(input string tag, input bit pc, input bit cm, input bit ack,
                       input logic [2:0] st, input bit ov, input bit hl, input bit bz);
      push_ctrl(0, tag, pc, cm, ack, st, ov, hl, bz);
      settle_and_check();
      @(negedge clk);
   endtask

   task automatic counts(input string tag, input int ic, input int sc);
      push_cnt(1, tag, ic, sc);
      settle_and_check();
   endtask

   initial begin
      rst_n = 1'b0; halt = 1'b0; ioen = 1'b0; iosel = 1'b0; op = 5'd0;
      inv = 1'b0; ordy = 1'b0; resume = 1'b1;
      #1;
      push_ctrl(0, "reset_ctrl", 0, 0, 0, 3'd0, 0, 0, 0);
      push_cnt(1, "reset_cnt", 0, 0);
      push_cnt(3, "reset_cnt_b", 0, 0);
      settle_and_check();
      @(negedge clk);
      rst_n = 1'b1;

      // Normal instructions
      for (int i = 0; i < 5; i++) step("normal", 1, 1, 0, 3'd0, 0, 0, 0);
      counts("cnt_normal", 5, 0);

      // DIV: A stalls 8 cycles, B (DIV_CYCLES=0) is single-cycle
      op = 5'd3;
      push_ctrl(2, "div_b_single", 1, 1, 0, 3'd0, 0, 0, 0);
      step("div_entry", 0, 0, 0, 3'd0, 0, 0, 0);
      op = 5'd0;
      for (int i = 0; i < 7; i++) step("div_wait", 0, 0, 0, 3'd1, 0, 0, 1);
      step("div_done", 1, 1, 0, 3'd1, 0, 0, 1);
      push_cnt(3, "cnt_div_b", 14, 0);
      counts("cnt_div", 6, 8);

      // IN, data arrives 4 cycles after entry
      ioen = 1'b1; iosel = 1'b0;
      step("in_entry", 0, 0, 0, 3'd0, 0, 0, 0);
      ioen = 1'b0;
      for (int i = 0; i < 3; i++) step("in_wait", 0, 0, 0, 3'd2, 0, 0, 1);
      inv = 1'b1;
      step("in_ack", 1, 1, 1, 3'd2, 0, 0, 1);
      inv = 1'b0;
      step("in_after", 1, 1, 0, 3'd0, 0, 0, 0);
      // IN with data already present: entry ignores In_Valid, 2 cycles total
      inv = 1'b1; ioen = 1'b1;
      step("in2_entry", 0, 0, 0, 3'd0, 0, 0, 0);
      ioen = 1'b0;
      step("in2_ack", 1, 1, 1, 3'd2, 0, 0, 1);
      inv = 1'b0;

      // OUT with Out_Ready low for 3 cycles
      ioen = 1'b1; iosel = 1'b1;
      step("out_entry", 0, 0, 0, 3'd0, 0, 0, 0);
      ioen = 1'b0;
      for (int i = 0; i < 3; i++) step("out_wait", 0, 0, 0, 3'd3, 1, 0, 1);
      ordy = 1'b1;
      step("out_done", 1, 1, 0, 3'd3, 1, 0, 1);
      ordy = 1'b0;
      step("out_after", 1, 1, 0, 3'd0, 0, 0, 0);
      // OUT with Out_Ready already high completes on first wait cycle
      ioen = 1'b1; ordy = 1'b1;
      step("out2_entry", 0, 0, 0, 3'd0, 0, 0, 0);
      ioen = 1'b0;
      step("out2_done", 1, 1, 0, 3'd3, 1, 0, 1);
      ordy = 1'b0; iosel = 1'b0;
      counts("cnt_io", 12, 18);

      // HALT with Resume held since reset: no edge
      halt = 1'b1;
      step("halt_entry", 0, 0, 0, 3'd0, 0, 0, 0);
      halt = 1'b0;
      for (int i = 0; i < 3; i++) step("halted", 0, 0, 0, 3'd4, 0, 1, 1);
      resume = 1'b0;
      step("halted_r0", 0, 0, 0, 3'd4, 0, 1, 1);
      resume = 1'b1;
      step("resume_step", 1, 0, 0, 3'd4, 0, 1, 1);
      step("resumed", 1, 1, 0, 3'd0, 0, 0, 0);
      counts("cnt_halt", 14, 19);
      // Halt again while Resume stays high: only one step per edge
      halt = 1'b1;
      step("halt2_entry", 0, 0, 0, 3'd0, 0, 0, 0);
      halt = 1'b0;
      for (int i = 0; i < 2; i++) step("halt2_held", 0, 0, 0, 3'd4, 0, 1, 1);
      resume = 1'b0;
      step("halt2_r0", 0, 0, 0, 3'd4, 0, 1, 1);
      resume = 1'b1;
      step("resume2_step", 1, 0, 0, 3'd4, 0, 1, 1);
      step("resumed2", 1, 1, 0, 3'd0, 0, 0, 0);
      counts("cnt_halt2", 16, 20);

      // Reset in the middle of DIV_WAIT
      op = 5'd4;
      step("mod_entry", 0, 0, 0, 3'd0, 0, 0, 0);
      op = 5'd0;
      for (int i = 0; i < 2; i++) step("mod_wait", 0, 0, 0, 3'd1, 0, 0, 1);
      rst_n = 1'b0;
      push_ctrl(0, "rst_div_ctrl", 0, 0, 0, 3'd0, 0, 0, 0);
      push_cnt(1, "rst_div_cnt", 0, 0);
      settle_and_check();
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_div", 1, 1, 0, 3'd0, 0, 0, 0);

      // Reset in the middle of OUT_WAIT, with Out_Ready raised during reset
      ioen = 1'b1; iosel = 1'b1;
      step("out3_entry", 0, 0, 0, 3'd0, 0, 0, 0);
      ioen = 1'b0;
      step("out3_wait", 0, 0, 0, 3'd3, 1, 0, 1);
      rst_n = 1'b0; ordy = 1'b1;
      push_ctrl(0, "rst_out_ctrl", 0, 0, 0, 3'd0, 0, 0, 0);
      push_cnt(1, "rst_out_cnt", 0, 0);
      push_cnt(3, "rst_out_cnt_b", 0, 0);
      settle_and_check();
      @(negedge clk);
      rst_n = 1'b1; ordy = 1'b0; iosel = 1'b0;
      step("post_rst_out", 1, 1, 0, 3'd0, 0, 0, 0);
      counts("cnt_final", 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
